// File: rtl/adder_bist.sv
// adder_bist: exhaustive built-in self-test for a WIDTH-bit adder.
// Sweeps every {cin, a, b} vector onto the adder inputs, samples the adder
// result one cycle later, compares it against cin + a + b and keeps
// pass/fail statistics plus the first failing vector.
module adder_bist #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  output logic                 dut_cin,
  output logic [WIDTH-1:0]     dut_a,
  output logic [WIDTH-1:0]     dut_b,
  input  logic [WIDTH-1:0]     dut_s,
  input  logic                 dut_cout,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_count,
  output logic [2*WIDTH+1:0]   test_count,
  output logic [2*WIDTH:0]     first_fail,
  output logic [WIDTH:0]       first_got
);

  localparam int VW = 2*WIDTH+1;
  localparam int CW = 2*WIDTH+2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e          state_q;
  logic [VW-1:0]   vec_q;
  logic            busy_q;
  logic            done_q;
  logic [CW-1:0]   err_q;
  logic [CW-1:0]   test_q;
  logic [VW-1:0]   ff_q;
  logic [WIDTH:0]  fg_q;

  // stage-1 sample registers: driving vector and observed {s, cout}
  logic            s1_vld_q;
  logic [VW-1:0]   s1_vec_q;
  logic [WIDTH:0]  s1_got_q;

  logic [WIDTH:0]  exp_d;
  logic [WIDTH:0]  got_d;
  logic            miss_d;

  // stimulus fields come straight from the vector register
  assign {dut_cin, dut_a, dut_b} = vec_q;

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = done_q && (err_q == '0);
  assign err_count  = err_q;
  assign test_count = test_q;
  assign first_fail = ff_q;
  assign first_got  = fg_q;

  // stage-2 compare: reference sum from the sampled vector, {cout, s} order
  always_comb begin
    exp_d  = {1'b0, s1_vec_q[2*WIDTH-1:WIDTH]}
           + {1'b0, s1_vec_q[WIDTH-1:0]}
           + {{WIDTH{1'b0}}, s1_vec_q[VW-1]};
    got_d  = {s1_got_q[0], s1_got_q[WIDTH:1]};
    miss_d = (exp_d != got_d);
  end

  // sweep FSM, sample pipeline and result counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= '0;
      test_q   <= '0;
      ff_q     <= '0;
      fg_q     <= '0;
      s1_vld_q <= 1'b0;
      s1_vec_q <= '0;
      s1_got_q <= '0;
    end else begin
      // sample whatever is driven; only RUN cycles carry a live vector
      s1_vec_q <= vec_q;
      s1_got_q <= {dut_s, dut_cout};
      s1_vld_q <= (state_q == RUN) && !abort;

      // commit a sampled vector unless the sweep is being aborted
      if (s1_vld_q && !abort) begin
        test_q <= test_q + CW'(1);
        if (miss_d) begin
          err_q <= err_q + CW'(1);
          if (err_q == '0) begin
            ff_q <= s1_vec_q;
            fg_q <= s1_got_q;
          end
        end
      end

      case (state_q)
        IDLE, DONE: begin
          // abort outranks start even when there is nothing to abort
          if (start && !abort) begin
            state_q <= RUN;
            vec_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= '0;
            test_q  <= '0;
            ff_q    <= '0;
            fg_q    <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            vec_q   <= '0;
          end else if (vec_q == {VW{1'b1}}) begin
            // last vector stays on the adder while it drains
            state_q <= DRAIN;
          end else begin
            vec_q <= vec_q + VW'(1);
          end
        end
        DRAIN: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            vec_q   <= '0;
          end else if (s1_vld_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            vec_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist.sv
// tb_adder_bist: drives adder_bist (WIDTH=4) with a behavioural adder that
// can carry injected faults, and checks the BIST results against a
// vector-by-vector reference computed from plain arithmetic.
module tb_adder_bist;

  localparam int W = 4;
  localparam int N = 1 << (2*W+1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic          dut_cin;
  logic [W-1:0]  dut_a;
  logic [W-1:0]  dut_b;
  logic [W-1:0]  dut_s;
  logic          dut_cout;
  logic          busy;
  logic          done;
  logic          pass;
  logic [2*W+1:0] err_count;
  logic [2*W+1:0] test_count;
  logic [2*W:0]  first_fail;
  logic [W:0]    first_got;

  int kind;
  int seed;
  int ncmp  = 0;
  int nfail = 0;
  logic [W:0] fs;

  adder_bist #(.WIDTH(W)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .dut_cin    (dut_cin),
    .dut_a      (dut_a),
    .dut_b      (dut_b),
    .dut_s      (dut_s),
    .dut_cout   (dut_cout),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .test_count (test_count),
    .first_fail (first_fail),
    .first_got  (first_got)
  );

  always #5 clk = ~clk;

  // adder result {cout, s} for vector v, with an optional fault
  function automatic int faulty_sum(input int k, input int sd, input int v);
    int r;
    r = ((v >> (2*W)) & 1) + ((v >> W) & ((1 << W) - 1)) + (v & ((1 << W) - 1));
    case (k)
      1: r = r & ~1;
      2: r = r & ((1 << W) - 1);
      3: if (((v * 37 + sd) % 11) == 0) r = r ^ ((sd % 31) + 1);
      default: ;
    endcase
    return r;
  endfunction

  always_comb fs = (W+1)'(faulty_sum(kind, seed, int'({dut_cin, dut_a, dut_b})));
  assign dut_cout = fs[W];
  assign dut_s    = fs[W-1:0];

  // reference: walk the first nc vectors in sweep order
  function automatic void model(input int k, input int sd, input int nc,
                                output int ec, output int ff, output int fg);
    ec = 0; ff = 0; fg = 0;
    for (int v = 0; v < nc; v++) begin
      int good;
      int got;
      good = (v >> (2*W)) + ((v >> W) & ((1 << W) - 1)) + (v & ((1 << W) - 1));
      got  = faulty_sum(k, sd, v);
      if (got != good) begin
        if (ec == 0) begin
          ff = v;
          fg = ((got & ((1 << W) - 1)) << 1) | ((got >> W) & 1);
        end
        ec++;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_tc"}, test_count, 0);
    check({tag, "_ff"}, first_fail, 0);
    check({tag, "_fg"}, first_got, 0);
    check({tag, "_dut"}, {dut_cin, dut_a, dut_b}, 0);
  endtask

  // one sweep: abort_at = edge index at which abort is sampled (0 = none)
  task automatic sweep(input int k, input int sd, input int abort_at, input bit noise);
    int e;
    int ec, ff, fg, nc;
    bit fin;
    kind = k;
    seed = sd;
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_on_start", busy, 1);
    check("tc_cleared", test_count, 0);
    check("done_cleared", done, 0);
    e = 0;
    fin = 1'b0;
    while (!fin && e < N + 20) begin
      e++;
      start = noise && (e >= 5) && (e <= 10);
      abort = (e == abort_at);
      step();
      start = 1'b0;
      abort = 1'b0;
      if (e == abort_at) fin = 1'b1;
      else if (done) fin = 1'b1;
      else if (e == N) check("busy_at_edgeN", busy, 1);
    end
    check("sweep_finished", fin, 1);
    nc = (abort_at != 0) ? ((e >= 2) ? e - 2 : 0) : N;
    model(k, sd, nc, ec, ff, fg);
    if (abort_at != 0) begin
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_pass", pass, 0);
    end else begin
      check("done_edge", e, N + 1);
      check("done_busy", busy, 0);
      check("pass", pass, (ec == 0));
    end
    check("test_count", test_count, nc);
    check("err_count", err_count, ec);
    check("first_fail", first_fail, ff);
    check("first_got", first_got, fg);
    check("dut_idle", {dut_cin, dut_a, dut_b}, 0);
    if (abort_at == 0) begin
      step();
      check("done_held", done, 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    kind  = 0;
    seed  = 0;
    step();
    step();
    check_idle_outputs("reset");
    reset = 1'b0;
    step();

    // golden adder
    sweep(0, 0, 0, 1'b0);

    // s[0] stuck-at-0: every odd sum is wrong, first at b=1
    sweep(1, 0, 0, 1'b0);
    check("s0_err", err_count, N / 2);
    check("s0_ff", first_fail, 9'h001);
    check("s0_fg", first_got, 0);

    // cout stuck-at-0: first carry is cin=0, a=1, b=15
    sweep(2, 0, 0, 1'b0);
    check("co_err", err_count, N / 2);
    check("co_ff", first_fail, 9'h01F);
    check("co_fg", first_got, 0);

    // start re-asserted mid-sweep must be ignored
    sweep(0, 0, 0, 1'b1);

    // abort sampled at edge 11, then a clean rerun
    sweep(0, 0, 11, 1'b0);
    check("abort11_tc", test_count, 9);
    sweep(0, 0, 0, 1'b0);

    // randomized fault masks and abort points
    for (int i = 0; i < 6; i++) begin
      int sd;
      int ab;
      sd = int'($urandom_range(0, 1000));
      ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, N + 1)) : 0;
      sweep(3, sd, ab, 1'b0);
    end

    // abort on the drain edge discards the final vector
    sweep(3, 17, N + 1, 1'b0);
    check("abort_drain_tc", test_count, N - 1);

    // asynchronous reset mid-sweep, between clock edges
    kind = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    #3 reset = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    step();
    reset = 1'b0;
    step();
    sweep(0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
